// File: rtl/adder_bist_checker.sv
// adder_bist_checker: on-chip self-test engine for a WIDTH-bit ripple adder.
// Sweeps every operand pair with B >= A, first with cin=0 and then with cin=1.
// Each adder response is compared against a full-width golden sum.
// Mismatches are counted in a saturating counter, and the first failing vector is captured.
module adder_bist_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH-1:0] OPER_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OPER_ONE    = WIDTH'(32'd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reference result: A + B + cin kept WIDTH+1 bits wide so the carry is never lost.
    function automatic logic [WIDTH:0] golden_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c
    );
        golden_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] settle_r;

    logic [WIDTH:0]   golden_s;
    logic             mismatch_s;
    logic [ERR_W-1:0] err_next_s;
    logic [WIDTH-1:0] next_a_s;
    logic [WIDTH-1:0] next_b_s;
    logic             next_cin_s;
    logic             last_s;

    // Response compare, saturating increment and next-vector generation for the CHECK state.
    always_comb begin
        golden_s   = golden_sum(dut_a, dut_b, dut_cin);
        mismatch_s = ({dut_cout, dut_sum} != golden_s);
        if (err_count == ERR_MAX) begin
            err_next_s = err_count;
        end else begin
            err_next_s = err_count + ERR_ONE;
        end
        next_a_s   = dut_a;
        next_b_s   = dut_b;
        next_cin_s = dut_cin;
        last_s     = 1'b0;
        if (dut_b != OPER_MAX) begin
            next_b_s = dut_b + OPER_ONE;
        end else if (dut_a != OPER_MAX) begin
            // B restarts at the new A so the sweep stays in the B >= A triangle.
            next_a_s = dut_a + OPER_ONE;
            next_b_s = dut_a + OPER_ONE;
        end else if (!dut_cin) begin
            next_cin_s = 1'b1;
            next_a_s   = {WIDTH{1'b0}};
            next_b_s   = {WIDTH{1'b0}};
        end else begin
            last_s = 1'b1;
        end
    end

    // Sweep sequencer: state, settle timing, vector drive, and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            settle_r   <= {CNT_W{1'b0}};
            dut_a      <= {WIDTH{1'b0}};
            dut_b      <= {WIDTH{1'b0}};
            dut_cin    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= {ERR_W{1'b0}};
            fail_valid <= 1'b0;
            fail_vec   <= {(2*WIDTH+1){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // A start from DONE behaves exactly like a start from IDLE.
                    if (start) begin
                        state_r    <= APPLY;
                        settle_r   <= {CNT_W{1'b0}};
                        dut_a      <= {WIDTH{1'b0}};
                        dut_b      <= {WIDTH{1'b0}};
                        dut_cin    <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= {ERR_W{1'b0}};
                        fail_valid <= 1'b0;
                        fail_vec   <= {(2*WIDTH+1){1'b0}};
                    end
                end
                APPLY: begin
                    if (settle_r == SETTLE_LAST) begin
                        settle_r <= {CNT_W{1'b0}};
                        state_r  <= CHECK;
                    end else begin
                        settle_r <= settle_r + CNT_ONE;
                    end
                end
                CHECK: begin
                    if (mismatch_s) begin
                        err_count <= err_next_s;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= {dut_cin, dut_a, dut_b};
                        end
                    end
                    if (last_s) begin
                        // The final vector stays on dut_* while in DONE.
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !mismatch_s && (err_count == {ERR_W{1'b0}});
                    end else begin
                        state_r <= APPLY;
                        dut_a   <= next_a_s;
                        dut_b   <= next_b_s;
                        dut_cin <= next_cin_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// tb_adder_bist_checker: directed bench for adder_bist_checker.
// It uses a behavioural 4-bit adder that can have a fault planted in it.
module tb_adder_bist_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dut_a;
    logic [3:0] dut_b;
    logic       dut_cin;
    logic [3:0] dut_sum;
    logic       dut_cout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic       fail_valid;
    logic [8:0] fail_vec;

    int total = 0;
    int bad   = 0;
    int fault = 0;   // 0 good, 1 ignores cin, 2 sum[0] stuck 0, 3 all outputs stuck 0

    logic [4:0] true_sum;
    logic [4:0] adder_res;

    adder_bist_checker #(.WIDTH(4), .SETTLE(1), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // Adder under test, with an optional planted fault.
    always_comb begin
        true_sum = {1'b0, dut_a} + {1'b0, dut_b} + {4'd0, dut_cin};
        case (fault)
            1:       adder_res = {1'b0, dut_a} + {1'b0, dut_b};
            2:       adder_res = true_sum & 5'b11110;
            3:       adder_res = 5'd0;
            default: adder_res = true_sum;
        endcase
    end
    assign dut_sum  = adder_res[3:0];
    assign dut_cout = adder_res[4];

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done, recording vectors seen while busy.
    // A stray start is raised after edge inject_at; rst is asserted after edge abort_at.
    task automatic run_sweep(input int inject_at, input int abort_at,
                             output int edges, output int distinct, output int order_bad);
        bit seen [512];
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
        edges = 0;
        distinct = 0;
        order_bad = 0;
        while (!done && edges < 3000) begin
            @(posedge clk);
            #1;
            edges++;
            start = (edges == inject_at);
            if (busy) begin
                seen[{dut_cin, dut_a, dut_b}] = 1'b1;
                if (dut_b < dut_a) order_bad++;
            end
            if (edges == abort_at) begin
                rst = 1'b1;
                break;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 512; i++) distinct += seen[i];
    endtask

    task automatic test_reset();
        pulse_start();
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, pass, err_count, fail_valid, fail_vec, dut_a, dut_b, dut_cin} !== 31'd0) begin
            bad++;
            $display("FAIL reset_async: outputs=%h required 0", {busy, done, pass, err_count, fail_valid, fail_vec, dut_a, dut_b, dut_cin});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: busy,done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_good_sweep();
        int e, d, ob;
        fault = 0;
        pulse_start();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL good_busy: busy=%b required 1", busy); end
        run_sweep(-1, -1, e, d, ob);
        total++;
        if (e !== 544) begin bad++; $display("FAIL good_latency: edges=%0d required 544", e); end
        total++;
        if (d !== 272) begin bad++; $display("FAIL good_distinct: vectors=%0d required 272", d); end
        total++;
        if (ob !== 0) begin bad++; $display("FAIL good_order: B<A seen %0d times required 0", ob); end
        total++;
        if ({done, pass, busy, fail_valid} !== 4'b1100) begin
            bad++; $display("FAIL good_flags: done,pass,busy,fail_valid=%b required 1100", {done, pass, busy, fail_valid});
        end
        total++;
        if (err_count !== 8'd0) begin bad++; $display("FAIL good_errs: err_count=%0d required 0", err_count); end
        total++;
        if ({dut_cin, dut_a, dut_b} !== 9'h1FF) begin
            bad++; $display("FAIL good_last_vec: vec=%h required 1ff", {dut_cin, dut_a, dut_b});
        end
    endtask

    task automatic test_fault(input int f, input logic [7:0] exp_err, input logic [8:0] exp_vec);
        int e, d, ob;
        fault = f;
        pulse_start();
        run_sweep(-1, -1, e, d, ob);
        total++;
        if (err_count !== exp_err) begin
            bad++; $display("FAIL fault%0d_errs: err_count=%0d required %0d", f, err_count, exp_err);
        end
        total++;
        if (fail_vec !== exp_vec) begin
            bad++; $display("FAIL fault%0d_vec: fail_vec=%h required %h", f, fail_vec, exp_vec);
        end
        total++;
        if ({done, pass, fail_valid} !== 3'b101) begin
            bad++; $display("FAIL fault%0d_flags: done,pass,fail_valid=%b required 101", f, {done, pass, fail_valid});
        end
    endtask

    task automatic test_start_in_done();
        int e, d, ob;
        fault = 0;
        pulse_start();
        total++;
        if ({busy, done, pass, err_count, fail_valid} !== {3'b100, 8'd0, 1'b0}) begin
            bad++; $display("FAIL restart_clear: busy,done,pass,err,fv=%b required 100000000000", {busy, done, pass, err_count, fail_valid});
        end
        run_sweep(-1, -1, e, d, ob);
        total++;
        if ({done, pass, err_count} !== {2'b11, 8'd0}) begin
            bad++; $display("FAIL restart_result: done,pass,err=%b required 1100000000", {done, pass, err_count});
        end
    endtask

    task automatic test_start_while_busy();
        int e, d, ob;
        fault = 0;
        pulse_start();
        run_sweep(100, -1, e, d, ob);
        total++;
        if (e !== 544) begin bad++; $display("FAIL busy_start_latency: edges=%0d required 544", e); end
        total++;
        if (d !== 272) begin bad++; $display("FAIL busy_start_distinct: vectors=%0d required 272", d); end
    endtask

    task automatic test_reset_mid_run();
        int e, d, ob;
        fault = 0;
        pulse_start();
        run_sweep(-1, 200, e, d, ob);
        #1;
        total++;
        if ({busy, done, pass, err_count, fail_valid, fail_vec, dut_a, dut_b, dut_cin} !== 31'd0) begin
            bad++; $display("FAIL midrun_reset: outputs=%h required 0", {busy, done, pass, err_count, fail_valid, fail_vec, dut_a, dut_b, dut_cin});
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        run_sweep(-1, -1, e, d, ob);
        total++;
        if (e !== 544 || pass !== 1'b1) begin
            bad++; $display("FAIL midrun_rerun: edges=%0d pass=%b required 544 and 1", e, pass);
        end
    endtask

    initial begin
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_good_sweep();
        test_fault(1, 8'd136, 9'h100);
        test_fault(2, 8'd136, 9'h001);
        test_fault(3, 8'd255, 9'h001);
        test_start_in_done();
        test_start_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
